// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one synchronous single-port memory: CPU port (r0) has priority,
// the DMA/loader port (r1) gets anti-starvation forcing and burst locking.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [15:0] r0_addr,
   input  logic [15:0] r0_wdata,
   output logic        r0_gnt,
   output logic        r0_rvalid,
   output logic [15:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [15:0] r1_addr,
   input  logic [15:0] r1_wdata,
   input  logic        r1_lock,
   output logic        r1_gnt,
   output logic        r1_rvalid,
   output logic [15:0] r1_rdata,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_write_data,
   input  logic [15:0] mem_read_data,
   output logic [3:0]  starve_cnt
);

   // Handshake: rN_req/we/addr/wdata are held by the requester until rN_gnt is seen high
   // in the same cycle; that cycle is the transfer. A granted read returns rN_rvalid with
   // rN_rdata exactly one cycle later; writes produce no response.

   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

   logic       r_owner;
   logic [3:0] r_starve_cnt;
   logic [1:0] r_rsel;

   logic w_req0;
   logic w_req1;
   logic w_force1;
   logic w_gnt0;
   logic w_gnt1;

   // Grants are combinational, so they must be masked while reset is held.
   assign w_req0   = r0_req & rst_n;
   assign w_req1   = r1_req & rst_n;
   assign w_force1 = w_req1 & (r_owner | (r_starve_cnt >= LP_LIMIT));
   assign w_gnt1   = w_req1 & (w_force1 | ~w_req0);
   assign w_gnt0   = w_req0 & ~w_force1;

   assign r0_gnt     = w_gnt0;
   assign r1_gnt     = w_gnt1;
   assign starve_cnt = r_starve_cnt;

   always_comb begin
      mem_read_en    = 1'b0;
      mem_write_en   = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      if (w_gnt0) begin
         mem_read_en    = ~r0_we;
         mem_write_en   = r0_we;
         mem_addr       = r0_addr;
         mem_write_data = r0_wdata;
      end else if (w_gnt1) begin
         mem_read_en    = ~r1_we;
         mem_write_en   = r1_we;
         mem_addr       = r1_addr;
         mem_write_data = r1_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner      <= 1'b0;
         r_starve_cnt <= '0;
         r_rsel       <= '0;
      end else begin
         if (w_req1 && !w_gnt1)
            r_starve_cnt <= (r_starve_cnt == 4'hF) ? r_starve_cnt : r_starve_cnt + 4'd1;
         else
            r_starve_cnt <= '0;

         if (w_gnt1 && r1_lock)
            r_owner <= 1'b1;
         else if (!r1_lock || !r1_req)
            r_owner <= 1'b0;

         r_rsel <= {w_gnt1 & ~r1_we, w_gnt0 & ~r0_we};
      end
   end

   // Read return routing: only the port that issued last cycle's read sees data.
   assign r0_rvalid = r_rsel[0];
   assign r1_rvalid = r_rsel[1];
   assign r0_rdata  = r_rsel[0] ? mem_read_data : '0;
   assign r1_rdata  = r_rsel[1] ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a small synchronous memory model, per-scenario tasks with inline
// grant/command checks, and a read-return scoreboard fed by the tasks.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0_req = 1'b0, r0_we = 1'b0;
   logic [15:0] r0_addr = '0, r0_wdata = '0;
   logic        r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
   logic [15:0] r1_addr = '0, r1_wdata = '0;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [15:0] r0_rdata, r1_rdata;
   logic        mem_read_en, mem_write_en;
   logic [15:0] mem_addr, mem_write_data;
   logic [15:0] mem_read_data = '0;
   logic [3:0]  starve_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [15:0] mem_arr [0:255];
   logic [15:0] ref_mem [0:255];
   // Entry: {r1 expected, r0 expected, data}
   logic [17:0] exp_q[$];
   logic [17:0] mon_e;
   logic [15:0] mon_d0, mon_d1;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_lock(r1_lock),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .starve_cnt(starve_cnt)
   );

   // Clock/reset block
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   // Synchronous memory model
   always @(posedge clk) begin
      if (mem_write_en) mem_arr[mem_addr[7:0]] <= mem_write_data;
      if (mem_read_en)  mem_read_data <= mem_arr[mem_addr[7:0]];
   end

   // Scoreboard: every read accepted last cycle must return now, nothing else may
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e  = exp_q.pop_front();
         mon_d0 = mon_e[16] ? mon_e[15:0] : 16'h0000;
         mon_d1 = mon_e[17] ? mon_e[15:0] : 16'h0000;
      end else begin
         mon_e  = '0;
         mon_d0 = '0;
         mon_d1 = '0;
      end
      vec_cnt++;
      if ({r1_rvalid, r0_rvalid, r1_rdata, r0_rdata} !== {mon_e[17], mon_e[16], mon_d1, mon_d0}) begin
         err_cnt++;
         $display("FAIL rd_return t=%0t: got rv1=%b rv0=%b rd1=%h rd0=%h, want rv1=%b rv0=%b rd1=%h rd0=%h",
                  $time, r1_rvalid, r0_rvalid, r1_rdata, r0_rdata, mon_e[17], mon_e[16], mon_d1, mon_d0);
      end
   end

   // Driver tasks
   task automatic set0(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
   endtask

   task automatic set1(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input logic lock);
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd; r1_lock = lock;
   endtask

   task automatic drive_idle();
      set0(1'b0, 1'b0, 16'h0000, 16'h0000);
      set1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set0(1'b1, 1'b0, 16'h0003, 16'h1234);
      set1(1'b1, 1'b1, 16'h0004, 16'h5678, 1'b1);
      #1;
      vec_cnt++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_read_en, mem_write_en, mem_addr, mem_write_data,
           r0_rdata, r1_rdata, starve_cnt} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got g0=%b g1=%b ren=%b wen=%b addr=%h wd=%h cnt=%0d, want all 0",
                  r0_gnt, r1_gnt, mem_read_en, mem_write_en, mem_addr, mem_write_data, starve_cnt);
      end
      tick();
      tick();
      drive_idle();
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 3; i++) begin
         drive_idle();
         #1;
         vec_cnt++;
         if ({r0_gnt, r1_gnt, mem_read_en, mem_write_en, mem_addr, mem_write_data, starve_cnt} !== '0) begin
            err_cnt++;
            $display("FAIL idle: got g0=%b g1=%b ren=%b wen=%b addr=%h cnt=%0d, want all 0",
                     r0_gnt, r1_gnt, mem_read_en, mem_write_en, mem_addr, starve_cnt);
         end
         tick();
      end
   endtask

   task automatic test_starve();
      logic        g0, g1;
      logic [3:0]  ecnt;
      logic [15:0] ea;
      set0(1'b1, 1'b0, 16'h0003, 16'h0000);
      set1(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         g1   = (i % 5) == 4;
         g0   = !g1;
         ecnt = 4'(i % 5);
         ea   = g1 ? 16'h0004 : 16'h0003;
         #1;
         vec_cnt++;
         if ({r0_gnt, r1_gnt, starve_cnt, mem_read_en, mem_write_en, mem_addr} !==
             {g0, g1, ecnt, 1'b1, 1'b0, ea}) begin
            err_cnt++;
            $display("FAIL starve[%0d]: got g0=%b g1=%b cnt=%0d ren=%b addr=%h, want g0=%b g1=%b cnt=%0d ren=1 addr=%h",
                     i, r0_gnt, r1_gnt, starve_cnt, mem_read_en, mem_addr, g0, g1, ecnt, ea);
         end
         exp_q.push_back({g1, g0, ref_mem[ea[7:0]]});
         tick();
      end
      drive_idle();
   endtask

   task automatic test_write_read();
      set0(1'b1, 1'b1, 16'h0010, 16'hBEEF);
      set1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #1;
      vec_cnt++;
      if ({r0_gnt, r1_gnt, mem_write_en, mem_read_en, mem_addr, mem_write_data} !==
          {1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF}) begin
         err_cnt++;
         $display("FAIL wr_cmd: got g0=%b wen=%b ren=%b addr=%h wd=%h, want g0=1 wen=1 ren=0 addr=0010 wd=beef",
                  r0_gnt, mem_write_en, mem_read_en, mem_addr, mem_write_data);
      end
      ref_mem[8'h10] = 16'hBEEF;
      tick();
      set0(1'b0, 1'b0, 16'h0000, 16'h0000);
      set1(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      #1;
      vec_cnt++;
      if ({r0_gnt, r1_gnt, mem_read_en, mem_write_en, mem_addr} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0010}) begin
         err_cnt++;
         $display("FAIL rd_cmd: got g1=%b ren=%b wen=%b addr=%h, want g1=1 ren=1 wen=0 addr=0010",
                  r1_gnt, mem_read_en, mem_write_en, mem_addr);
      end
      exp_q.push_back({1'b1, 1'b0, ref_mem[8'h10]});
      tick();
      drive_idle();
      tick();
   endtask

   task automatic test_lock();
      logic [15:0] a;
      set0(1'b0, 1'b0, 16'h0000, 16'h0000);
      set1(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1);
      #1;
      vec_cnt++;
      if ({r0_gnt, r1_gnt} !== 2'b01) begin
         err_cnt++;
         $display("FAIL lock_first: got g0=%b g1=%b, want g0=0 g1=1", r0_gnt, r1_gnt);
      end
      exp_q.push_back({1'b1, 1'b0, ref_mem[8'h20]});
      tick();
      set0(1'b1, 1'b1, 16'h0030, 16'hDEAD);
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom_range(0, 255));
         set1(1'b1, 1'b0, a, 16'h0000, 1'b1);
         #1;
         vec_cnt++;
         if ({r0_gnt, r1_gnt, mem_write_en, mem_read_en, mem_addr, starve_cnt} !==
             {1'b0, 1'b1, 1'b0, 1'b1, a, 4'd0}) begin
            err_cnt++;
            $display("FAIL lock_hold[%0d]: got g0=%b g1=%b wen=%b addr=%h cnt=%0d, want g0=0 g1=1 wen=0 addr=%h cnt=0",
                     i, r0_gnt, r1_gnt, mem_write_en, mem_addr, starve_cnt, a);
         end
         exp_q.push_back({1'b1, 1'b0, ref_mem[a[7:0]]});
         tick();
      end
      set1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #1;
      vec_cnt++;
      if ({r0_gnt, r1_gnt, mem_write_en, mem_addr, mem_write_data} !==
          {1'b1, 1'b0, 1'b1, 16'h0030, 16'hDEAD}) begin
         err_cnt++;
         $display("FAIL lock_release: got g0=%b g1=%b wen=%b addr=%h wd=%h, want g0=1 g1=0 wen=1 addr=0030 wd=dead",
                  r0_gnt, r1_gnt, mem_write_en, mem_addr, mem_write_data);
      end
      ref_mem[8'h30] = 16'hDEAD;
      tick();
      drive_idle();
   endtask

   task automatic test_alternate();
      logic g1;
      for (int i = 0; i < 8; i++) begin
         g1 = i[0];
         if (g1) begin
            set0(1'b0, 1'b0, 16'h0000, 16'h0000);
            set1(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
         end else begin
            set0(1'b1, 1'b0, 16'h0001, 16'h0000);
            set1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
         end
         #1;
         vec_cnt++;
         if ({r0_gnt, r1_gnt, mem_read_en, mem_addr} !== {!g1, g1, 1'b1, g1 ? 16'h0002 : 16'h0001}) begin
            err_cnt++;
            $display("FAIL alternate[%0d]: got g0=%b g1=%b ren=%b addr=%h, want g0=%b g1=%b ren=1",
                     i, r0_gnt, r1_gnt, mem_read_en, mem_addr, !g1, g1);
         end
         exp_q.push_back({g1, !g1, ref_mem[g1 ? 8'h02 : 8'h01]});
         tick();
      end
      drive_idle();
   endtask

   task automatic test_back_to_back();
      logic        who, we;
      logic [15:0] a, d;
      for (int i = 0; i < 24; i++) begin
         who = 1'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         a   = 16'($urandom_range(0, 255));
         d   = 16'($urandom);
         if (who) begin
            set0(1'b0, 1'b0, 16'h0000, 16'h0000);
            set1(1'b1, we, a, d, 1'b0);
         end else begin
            set0(1'b1, we, a, d);
            set1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
         end
         #1;
         vec_cnt++;
         if ({r0_gnt, r1_gnt, mem_read_en, mem_write_en, mem_addr, mem_write_data} !==
             {!who, who, !we, we, a, d}) begin
            err_cnt++;
            $display("FAIL b2b[%0d]: got g0=%b g1=%b ren=%b wen=%b addr=%h wd=%h, want g0=%b g1=%b ren=%b wen=%b addr=%h wd=%h",
                     i, r0_gnt, r1_gnt, mem_read_en, mem_write_en, mem_addr, mem_write_data,
                     !who, who, !we, we, a, d);
         end
         if (we) ref_mem[a[7:0]] = d;
         else    exp_q.push_back({who, !who, ref_mem[a[7:0]]});
         tick();
      end
      drive_idle();
      tick();
   endtask

   task automatic test_reset_mid();
      set0(1'b1, 1'b0, 16'h0005, 16'h0000);
      set1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #1;
      vec_cnt++;
      if ({r0_gnt, mem_read_en} !== 2'b11) begin
         err_cnt++;
         $display("FAIL rst_mid_grant: got g0=%b ren=%b, want g0=1 ren=1", r0_gnt, mem_read_en);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_read_en, mem_write_en, mem_addr, r0_rdata,
           starve_cnt} !== '0) begin
         err_cnt++;
         $display("FAIL rst_mid_outputs: got g0=%b rv0=%b ren=%b addr=%h rd0=%h cnt=%0d, want all 0",
                  r0_gnt, r0_rvalid, mem_read_en, mem_addr, r0_rdata, starve_cnt);
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      set0(1'b1, 1'b0, 16'h0007, 16'h0000);
      #1;
      vec_cnt++;
      if ({r0_gnt, mem_read_en, mem_addr} !== {1'b1, 1'b1, 16'h0007}) begin
         err_cnt++;
         $display("FAIL first_grant: got g0=%b ren=%b addr=%h, want g0=1 ren=1 addr=0007",
                  r0_gnt, mem_read_en, mem_addr);
      end
      exp_q.push_back({1'b0, 1'b1, ref_mem[8'h07]});
      tick();
      drive_idle();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 16'hA000 + 16'(i);
         ref_mem[i] = 16'hA000 + 16'(i);
      end
      @(negedge clk);
      test_reset();
      test_idle();
      test_starve();
      test_write_read();
      test_lock();
      test_alternate();
      test_back_to_back();
      test_reset_mid();
      test_idle();
      tick();
      vec_cnt++;
      if (exp_q.size() !== 0) begin
         err_cnt++;
         $display("FAIL drain: got %0d reads outstanding, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied cycles of requester 1 before it is forced a grant; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 r0_req  input  1  CPU data-port request; r0_we  input  1  1=write, 0=read.
REQ-005 r0_addr  input  16  CPU word address; r0_wdata  input  16  CPU write data.
REQ-006 r0_gnt  output  1  CPU request accepted this cycle; r0_rvalid  output  1  CPU read data valid; r0_rdata  output  16  CPU read data.
REQ-007 r1_req, r1_we, r1_addr[16], r1_wdata[16], r1_lock  inputs  secondary requester (DMA/loader); r1_lock holds ownership across a burst.
REQ-008 r1_gnt  output  1;  r1_rvalid  output  1;  r1_rdata  output  16  (meaning as for r0).
REQ-009 mem_read_en  output  1;  mem_write_en  output  1;  mem_addr  output  16;  mem_write_data  output  16  shared single-port memory command.
REQ-010 mem_read_data  input  16  synchronous memory read data, valid one cycle after mem_read_en.
REQ-011 starve_cnt  output  4  current requester-1 consecutive-wait count (debug).

Function
REQ-012 Grant SHALL be combinational from current requests and registered state; at most one of r0_gnt/r1_gnt high in any cycle.
REQ-013 Default priority: requester 0 wins when both request, except per REQ-014/REQ-015.
REQ-014 starve_cnt increments each cycle r1_req=1 and r1_gnt=0, saturating at 15; clears to 0 on any cycle r1_gnt=1 or r1_req=0.
REQ-015 When starve_cnt >= STARVE_LIMIT and r1_req=1, r1_gnt SHALL be 1 irrespective of r0_req.
REQ-016 Lock: owner register (NONE/R1); set to R1 on a cycle with r1_gnt=1 and r1_lock=1; cleared on the first cycle r1_lock=0 or r1_req=0.
REQ-017 While owner=R1 and r1_req=1, r1_gnt=1 and r0_gnt=0 every cycle.
REQ-018 Memory command SHALL be the granted requester's we/addr/wdata: mem_read_en = gnt & ~we, mem_write_en = gnt & we; with no grant, all mem_* outputs are 0.
REQ-019 Read return: rsel register records which requester was granted a read; in the next cycle the matching rN_rvalid=1 and rN_rdata=mem_read_data; non-matching rdata SHALL be 0.
REQ-020 Read latency from accepted read to rvalid is exactly 1 cycle; back-to-back reads every cycle SHALL be supported, including alternating requesters.
REQ-021 Writes complete in the grant cycle; no response is generated for writes.
REQ-022 Requests held high while not granted SHALL remain pending with no side effects; a requester may drop req at any time.
REQ-023 No cycle SHALL ever have mem_read_en and mem_write_en both high.

Reset
REQ-024 While rst_n=0: r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_read_en, mem_write_en = 0; all data/address outputs = 0; starve_cnt=0; owner=NONE; rsel cleared.
REQ-025 Reset asserted mid-operation SHALL drop any pending read return (no rvalid after rst_n rises) and release any lock.
REQ-026 First grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-027 Both requesting reads continuously, STARVE_LIMIT=4 -> r0 granted 4 cycles, r1 granted on cycle 5, pattern repeats; starve_cnt 0,1,2,3,4,0.
REQ-028 r0 write addr 0x0010 data 0xBEEF, then r1 read 0x0010 -> mem_write_en cycle N; r1_rvalid cycle N+2 with r1_rdata=0xBEEF, r0_rvalid stays 0.
REQ-029 r1_lock=1 with r1_req for 6 cycles, r0_req constantly high -> r1_gnt 6 consecutive cycles (after initial grant), r0_gnt=0 throughout, r0 granted the cycle lock drops.
REQ-030 Alternating single reads r0 0x0001 / r1 0x0002 each cycle -> each rvalid 1 cycle after its grant with correct data; never both rvalid high.
REQ-031 rst_n pulled low the cycle after an r0 read grant -> r0_rvalid never asserts; all outputs 0 during reset.
REQ-032 Idle (no requests) -> all mem_* and gnt outputs 0, starve_cnt 0.
